// File: rtl/dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// dispatch_ctrl
//   Dispatch stage between instruction decode and the out-of-order back end.
//   Accepts one decoded instruction per cycle, allocates a ROB tag for it,
//   checks reservation-station credits for its unit class and emits a
//   registered dispatch pulse. SYSTEM instructions are serialized (they wait
//   for an empty ROB and block everything behind them until they retire), and
//   a mispredict flush rewinds the ROB tail and restores all credits.
//
// Ports
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_unit/      decoded instruction from decode; in_unit is
//   in_ctrl                0 ALU, 1 LSU, 2 BRANCH, 3 SYSTEM
//   in_ready               instruction accepted this cycle (combinational)
//   disp_valid/unit/tag/   registered dispatch; unit/tag/ctrl hold their last
//   disp_ctrl              values while disp_valid is low
//   credit_ret[2:0]        credit return pulses: [0] ALU, [1] LSU, [2] BRANCH
//   commit_valid           oldest ROB entry retires
//   flush, flush_tag       mispredict flush; flush_tag is the youngest kept
//   rob_count, rob_full    ROB occupancy
//   serial_busy            waiting for the ROB to drain around a SYSTEM op
// ----------------------------------------------------------------------------
module dispatch_ctrl #(
    parameter int ROB_DEPTH   = 16,
    parameter int TAG_W       = 4,
    parameter int CTRL_W      = 64,
    parameter int ALU_CREDITS = 4,
    parameter int LSU_CREDITS = 4,
    parameter int BR_CREDITS  = 2,
    parameter int RECOVER_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [1:0]        in_unit,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              in_ready,
    output logic              disp_valid,
    output logic [1:0]        disp_unit,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [CTRL_W-1:0] disp_ctrl,
    input  logic [2:0]        credit_ret,
    input  logic              commit_valid,
    input  logic              flush,
    input  logic [TAG_W-1:0]  flush_tag,
    output logic [TAG_W:0]    rob_count,
    output logic              rob_full,
    output logic              serial_busy
);

    localparam int CRED_MAX_AL = (ALU_CREDITS > LSU_CREDITS) ? ALU_CREDITS : LSU_CREDITS;
    localparam int CRED_MAX    = (CRED_MAX_AL > BR_CREDITS) ? CRED_MAX_AL : BR_CREDITS;
    localparam int CRED_W      = $clog2(CRED_MAX + 1);
    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(ROB_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_SERIAL_WAIT = 2'd1,
        ST_RECOVER     = 2'd2
    } state_t;

    state_t           state_reg;
    logic [2:0]       recov_cnt_reg;
    logic [TAG_W-1:0] head_reg;
    logic [TAG_W-1:0] tail_reg;
    logic [TAG_W:0]   count_reg;

    logic             disp_valid_reg;
    logic [1:0]       disp_unit_reg;
    logic [TAG_W-1:0] disp_tag_reg;
    logic [CTRL_W-1:0] disp_ctrl_reg;

    // Bit 3 (SYSTEM) never has credits; it keeps the class index in range.
    logic [3:0]       credit_ok;
    logic             is_system;
    logic             class_ok;
    logic             accept;
    logic [TAG_W-1:0] keep_span;

    assign credit_ok[3] = 1'b0;
    assign is_system    = (in_unit == 2'd3);

    // ------------------------------------------------------------------
    // Per-class reservation-station credit counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_credit
            localparam int MAXC = (gi == 0) ? ALU_CREDITS :
                                  (gi == 1) ? LSU_CREDITS : BR_CREDITS;
            logic [CRED_W-1:0] credit_reg;
            logic              take;
            logic              give;

            assign take = accept && (in_unit == 2'(gi));
            assign give = credit_ret[gi];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    credit_reg <= CRED_W'(MAXC);
                end else if (flush) begin
                    // Everything younger than the branch is gone from the
                    // stations, so every credit comes back at once.
                    credit_reg <= CRED_W'(MAXC);
                end else if (take && !give) begin
                    credit_reg <= credit_reg - 1'b1;
                end else if (give && !take) begin
                    if (credit_reg != CRED_W'(MAXC)) begin
                        credit_reg <= credit_reg + 1'b1;
                    end
                end
            end

            assign credit_ok[gi] = (credit_reg != '0);

            // A return while already at max means the back end lost track.
            a_credit_ovf : assert property (@(posedge clk) disable iff (!reset_n)
                !(give && !take && !flush && credit_reg == CRED_W'(MAXC)));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Acceptance
    // ------------------------------------------------------------------
    always_comb begin
        class_ok = 1'b0;
        if (is_system) begin
            class_ok = (count_reg == '0);
        end else begin
            class_ok = (count_reg < DEPTH_C) && credit_ok[in_unit];
        end
    end

    assign in_ready = (state_reg == ST_RUN) && !flush && class_ok;
    assign accept   = in_valid && in_ready;

    // Entries kept on a flush run from head up to and including flush_tag.
    assign keep_span = flush_tag - head_reg;

    // ------------------------------------------------------------------
    // ROB pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            tail_reg  <= flush_tag + 1'b1;
            count_reg <= {1'b0, keep_span} + 1'b1;
        end else begin
            if (accept) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (commit_valid) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({accept, commit_valid})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Dispatch output registers. accept is already low in a flush cycle,
    // so no dispatch can follow a flush.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_valid_reg <= 1'b0;
            disp_unit_reg  <= '0;
            disp_tag_reg   <= '0;
            disp_ctrl_reg  <= '0;
        end else begin
            disp_valid_reg <= accept;
            if (accept) begin
                disp_unit_reg <= in_unit;
                disp_tag_reg  <= tail_reg;
                disp_ctrl_reg <= in_ctrl;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_RUN;
            recov_cnt_reg <= '0;
        end else if (flush) begin
            state_reg     <= ST_RECOVER;
            recov_cnt_reg <= 3'(RECOVER_CYC - 1);
        end else begin
            case (state_reg)
                ST_RUN: begin
                    // A SYSTEM op either waits for the drain or, if the ROB is
                    // already empty, is accepted and then waits for itself.
                    if (in_valid && is_system) begin
                        state_reg <= ST_SERIAL_WAIT;
                    end
                end
                ST_SERIAL_WAIT: begin
                    if (count_reg == '0) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RECOVER: begin
                    if (recov_cnt_reg == '0) begin
                        state_reg <= ST_RUN;
                    end else begin
                        recov_cnt_reg <= recov_cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    assign disp_valid  = disp_valid_reg;
    assign disp_unit   = disp_unit_reg;
    assign disp_tag    = disp_tag_reg;
    assign disp_ctrl   = disp_ctrl_reg;
    assign rob_count   = count_reg;
    assign rob_full    = (count_reg == DEPTH_C);
    assign serial_busy = (state_reg == ST_SERIAL_WAIT);

endmodule

// File: tb/tb_dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dispatch_ctrl
//   Directed bench for dispatch_ctrl: tag allocation, credit exhaustion and
//   return, ROB full and wrap, SYSTEM serialization, flush recovery,
//   simultaneous accept/commit/return, and asynchronous reset mid-burst.
//   Inputs change 1 time unit after the rising edge; registered outputs are
//   checked there, in_ready one unit later once the inputs have settled.
// ----------------------------------------------------------------------------
module tb_dispatch_ctrl;

    localparam int TAG_W  = 4;
    localparam int CTRL_W = 64;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic [1:0]        in_unit;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_ready;
    logic              disp_valid;
    logic [1:0]        disp_unit;
    logic [TAG_W-1:0]  disp_tag;
    logic [CTRL_W-1:0] disp_ctrl;
    logic [2:0]        credit_ret;
    logic              commit_valid;
    logic              flush;
    logic [TAG_W-1:0]  flush_tag;
    logic [TAG_W:0]    rob_count;
    logic              rob_full;
    logic              serial_busy;

    int checks = 0;
    int errors = 0;

    dispatch_ctrl #(
        .ROB_DEPTH  (16),
        .TAG_W      (TAG_W),
        .CTRL_W     (CTRL_W),
        .ALU_CREDITS(4),
        .LSU_CREDITS(4),
        .BR_CREDITS (2),
        .RECOVER_CYC(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_unit     (in_unit),
        .in_ctrl     (in_ctrl),
        .in_ready    (in_ready),
        .disp_valid  (disp_valid),
        .disp_unit   (disp_unit),
        .disp_tag    (disp_tag),
        .disp_ctrl   (disp_ctrl),
        .credit_ret  (credit_ret),
        .commit_valid(commit_valid),
        .flush       (flush),
        .flush_tag   (flush_tag),
        .rob_count   (rob_count),
        .rob_full    (rob_full),
        .serial_busy (serial_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per dispatched instruction.
    always @(negedge clk) begin
        if (reset_n && disp_valid) begin
            $display("dispatch: tag=%0d unit=%0d ctrl=%h rob_count=%0d",
                     disp_tag, disp_unit, disp_ctrl, rob_count);
        end
    end

    // Bench-side protocol guard: commit never with flush or an empty ROB.
    always @(posedge clk) begin
        if (reset_n && commit_valid && (flush || rob_count == '0)) begin
            errors++;
            $error("FAIL commit_protocol: observed flush=%0b rob_count=%0d required no commit",
                   flush, rob_count);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid     = 1'b0;
        in_unit      = 2'd0;
        in_ctrl      = '0;
        credit_ret   = 3'b000;
        commit_valid = 1'b0;
        flush        = 1'b0;
        flush_tag    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;

        // ---------------- reset values ----------------
        tick();
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_unit", disp_unit, 0);
        chk("rst_disp_tag", disp_tag, 0);
        chk("rst_disp_ctrl", disp_ctrl, 0);
        chk("rst_rob_count", rob_count, 0);
        chk("rst_rob_full", rob_full, 0);
        chk("rst_serial_busy", serial_busy, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        #2 reset_n = 1'b1;

        // ---------------- T1: ALU credits ----------------
        in_valid = 1'b1;
        in_unit  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            in_ctrl = 64'hA000 + 64'(i);
            #1 chk("t1_ready", in_ready, 1);
            tick();
            chk("t1_valid", disp_valid, 1);
            chk("t1_tag", disp_tag, i);
            chk("t1_unit", disp_unit, 0);
            chk("t1_ctrl", disp_ctrl, 64'hA000 + 64'(i));
        end
        in_ctrl = 64'hA004;
        #1 chk("t1_no_credit", in_ready, 0);
        tick();
        chk("t1_pulse_end", disp_valid, 0);
        chk("t1_tag_hold", disp_tag, 3);
        chk("t1_ctrl_hold", disp_ctrl, 64'hA003);
        credit_ret = 3'b001;
        #1 chk("t1_ret_same_cycle", in_ready, 0);
        tick();
        credit_ret = 3'b000;
        #1 chk("t1_after_ret", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t1_tag4_valid", disp_valid, 1);
        chk("t1_tag4", disp_tag, 4);
        chk("t1_tag4_ctrl", disp_ctrl, 64'hA004);
        chk("t1_count", rob_count, 5);

        // ---------------- T2: ROB full and wrap ----------------
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_unit    = (k % 2 == 1) ? 2'd1 : 2'd0;
            credit_ret = (k % 2 == 1) ? 3'b010 : 3'b001;
            in_ctrl    = 64'hB000 + 64'(k);
            #1 chk("t2_ready", in_ready, 1);
            tick();
            chk("t2_tag", disp_tag, k);
        end
        credit_ret = 3'b000;
        in_unit    = 2'd0;
        in_ctrl    = 64'hB0FF;
        chk("t2_full", rob_full, 1);
        chk("t2_count16", rob_count, 16);
        #1 chk("t2_full_blocks", in_ready, 0);
        tick();
        chk("t2_no_disp", disp_valid, 0);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        chk("t2_count15", rob_count, 15);
        chk("t2_not_full", rob_full, 0);
        #1 chk("t2_ready_after_commit", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t2_wrap_valid", disp_valid, 1);
        chk("t2_wrap_tag", disp_tag, 0);
        chk("t2_wrap_count", rob_count, 16);

        // ---------------- T3: SYSTEM serialization ----------------
        do_reset();
        in_valid = 1'b1;
        in_unit  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            in_ctrl = 64'hC000 + 64'(i);
            #1;
            tick();
            chk("t3_alu_tag", disp_tag, i);
        end
        in_unit = 2'd3;
        in_ctrl = 64'hC0DE;
        #1 chk("t3_sys_blocked", in_ready, 0);
        tick();
        chk("t3_serial_busy", serial_busy, 1);
        chk("t3_no_disp", disp_valid, 0);
        chk("t3_count3", rob_count, 3);
        commit_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_wait_ready", in_ready, 0);
            tick();
        end
        commit_valid = 1'b0;
        chk("t3_drained", rob_count, 0);
        chk("t3_still_wait", serial_busy, 1);
        #1 chk("t3_wait_ready_last", in_ready, 0);
        tick();
        chk("t3_back_run", serial_busy, 0);
        #1 chk("t3_sys_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_unit  = 2'd0;
        chk("t3_sys_valid", disp_valid, 1);
        chk("t3_sys_unit", disp_unit, 3);
        chk("t3_sys_tag", disp_tag, 3);
        chk("t3_sys_ctrl", disp_ctrl, 64'hC0DE);
        chk("t3_sys_busy", serial_busy, 1);
        chk("t3_sys_count", rob_count, 1);
        #1 chk("t3_sys_blocks_alu", in_ready, 0);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        chk("t3_sys_retired", rob_count, 0);
        chk("t3_sys_wait_hold", serial_busy, 1);
        tick();
        chk("t3_sys_done", serial_busy, 0);
        #1 chk("t3_alu_ready", in_ready, 1);

        // ---------------- T4: flush recovery ----------------
        do_reset();
        in_valid = 1'b1;
        in_unit  = 2'd0;
        for (int k = 0; k < 9; k++) begin
            credit_ret = (k < 5) ? 3'b001 : 3'b000;
            in_ctrl    = 64'hD000 + 64'(k);
            #1 chk("t4_ready", in_ready, 1);
            tick();
            chk("t4_tag", disp_tag, k);
        end
        in_valid     = 1'b0;
        credit_ret   = 3'b000;
        commit_valid = 1'b1;
        tick();
        tick();
        commit_valid = 1'b0;
        chk("t4_pre_count", rob_count, 7);
        flush      = 1'b1;
        flush_tag  = 4'd4;
        credit_ret = 3'b111;
        in_valid   = 1'b1;
        in_unit    = 2'd0;
        in_ctrl    = 64'hE000;
        #1 chk("t4_flush_ready", in_ready, 0);
        tick();
        flush      = 1'b0;
        credit_ret = 3'b000;
        chk("t4_flush_count", rob_count, 3);
        chk("t4_flush_no_disp", disp_valid, 0);
        #1 chk("t4_recover1", in_ready, 0);
        tick();
        chk("t4_recover2", in_ready, 0);
        tick();
        chk("t4_recover_done", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            in_ctrl = 64'hE000 + 64'(k);
            #1 chk("t4_post_ready", in_ready, 1);
            tick();
            chk("t4_post_tag", disp_tag, 5 + k);
        end
        #1 chk("t4_credits_max4", in_ready, 0);
        in_valid = 1'b0;
        chk("t4_post_count", rob_count, 7);

        // ---------------- T5: accept + commit + return ----------------
        in_valid = 1'b1;
        in_unit  = 2'd1;
        in_ctrl  = 64'hF000;
        #1 chk("t5_ready", in_ready, 1);
        tick();
        chk("t5_tag9", disp_tag, 9);
        chk("t5_count8", rob_count, 8);
        in_ctrl      = 64'hF001;
        commit_valid = 1'b1;
        credit_ret   = 3'b010;
        #1 chk("t5_ready_combo", in_ready, 1);
        tick();
        commit_valid = 1'b0;
        credit_ret   = 3'b000;
        chk("t5_tag10", disp_tag, 10);
        chk("t5_count_same", rob_count, 8);
        for (int k = 0; k < 3; k++) begin
            in_ctrl = 64'hF002 + 64'(k);
            #1 chk("t5_lsu_ready", in_ready, 1);
            tick();
            chk("t5_lsu_tag", disp_tag, 11 + k);
        end
        #1 chk("t5_lsu_credit_kept", in_ready, 0);
        in_valid = 1'b0;
        chk("t5_count11", rob_count, 11);

        // ---------------- T6: async reset mid-burst ----------------
        do_reset();
        in_valid = 1'b1;
        in_unit  = 2'd0;
        for (int k = 0; k < 2; k++) begin
            credit_ret = 3'b001;
            in_ctrl    = 64'h5000 + 64'(k);
            #1;
            tick();
        end
        chk("t6_burst_valid", disp_valid, 1);
        chk("t6_burst_count", rob_count, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_valid", disp_valid, 0);
        chk("t6_async_count", rob_count, 0);
        chk("t6_async_tag", disp_tag, 0);
        clear_inputs();
        tick();
        #3 reset_n = 1'b1;
        in_valid = 1'b1;
        in_unit  = 2'd0;
        in_ctrl  = 64'h1234;
        #1 chk("t6_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t6_first_valid", disp_valid, 1);
        chk("t6_first_tag", disp_tag, 0);
        chk("t6_first_count", rob_count, 1);
        tick();
        chk("t6_single_pulse", disp_valid, 0);
        chk("t6_tag_hold", disp_tag, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sits between the decode stage (control_unit output) and the out-of-order back end.
- Accepts one decoded instruction per cycle and allocates a reorder-buffer (ROB) tag for it.
- Checks reservation-station credits for the target unit class (ALU / LSU / BRANCH), then dispatches with registered outputs.
- Serializes SYSTEM-class instructions and recovers ROB/credit state on a branch-mispredict flush.

Parameters:
- ROB_DEPTH, 16, ROB entries; power of two, at least 4.
- TAG_W, 4, ROB tag width, equal to log2(ROB_DEPTH).
- CTRL_W, 64, width of the opaque decoded control word passed through.
- ALU_CREDITS, 4, ALU reservation-station entries.
- LSU_CREDITS, 4, LSU reservation-station entries.
- BR_CREDITS, 2, BRANCH reservation-station entries.
- RECOVER_CYC, 2, cycles input stays blocked after a flush (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_unit  in  2  unit class: 0 ALU, 1 LSU, 2 BRANCH, 3 SYSTEM.
- in_ctrl  in  CTRL_W  decoded control word.
- in_ready  out  1  instruction accepted this cycle (combinational).
- disp_valid  out  1  dispatch pulse (registered).
- disp_unit  out  2  class of dispatched instruction.
- disp_tag  out  TAG_W  ROB tag allocated.
- disp_ctrl  out  CTRL_W  control word of dispatched instruction.
- credit_ret  in  3  per-class credit return pulse: [0] ALU, [1] LSU, [2] BR.
- commit_valid  in  1  oldest ROB entry retires.
- flush  in  1  mispredict flush pulse.
- flush_tag  in  TAG_W  tag of the mispredicted branch; it is the youngest entry kept.
- rob_count  out  TAG_W+1  occupied ROB entries.
- rob_full  out  1  rob_count == ROB_DEPTH.
- serial_busy  out  1  FSM in SERIAL_WAIT.

Behaviour:
- Reset values:
  - All outputs 0, except in_ready, which follows its equation with state RUN, rob_count 0 and full credits.
  - head = tail = 0; credits at their maxima; FSM in RUN.
- FSM states: RUN, SERIAL_WAIT, RECOVER.
- in_ready, ALU/LSU/BR class: state == RUN, !flush, rob_count < ROB_DEPTH, and credit[class] > 0.
- in_ready, SYSTEM class: state == RUN, !flush, and rob_count == 0.
- Accept = in_valid && in_ready. On accept:
  - disp_* registered next cycle; latency 1. disp_tag = tail.
  - tail increments mod ROB_DEPTH.
  - rob_count increments.
  - credit[class] decrements (ALU/LSU/BR only).
- disp_valid is a single-cycle pulse per accept. disp_unit, disp_tag and disp_ctrl hold their last values when disp_valid = 0.
- Transitions:
  - RUN -> SERIAL_WAIT: in_valid with class SYSTEM and rob_count != 0 (not accepted), or a SYSTEM instruction accepted.
  - SERIAL_WAIT -> RUN: when rob_count == 0. in_ready = 0 throughout SERIAL_WAIT.
- Any state -> RECOVER on flush. RECOVER holds RECOVER_CYC cycles via a counter, then returns to RUN. in_ready = 0 throughout RECOVER.
- Flush cycle:
  - tail <= flush_tag + 1 mod ROB_DEPTH.
  - rob_count <= ((flush_tag - head) mod ROB_DEPTH) + 1.
  - All credits restored to max; credit_ret in the same cycle is ignored.
  - disp_valid forced 0 next cycle.
  - A flush during SERIAL_WAIT abandons the wait.
- commit_valid: head increments mod ROB_DEPTH and rob_count decrements.
  - Accept and commit in the same cycle: rob_count unchanged, both pointers advance.
  - commit_valid is never asserted in a flush cycle or when rob_count == 0. The bench asserts this; RTL behaviour is undefined if violated.
- Credit arithmetic: a dispatch and a return for the same class in one cycle leave the credit unchanged. A credit never exceeds its max; overflow is an assertion failure.
- Pointer wrap: tag ROB_DEPTH-1 is followed by tag 0. rob_full blocks acceptance; rob_count saturates at ROB_DEPTH by construction.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); no dispatch is emitted.

Test Plan:
- Reset, then 4 consecutive ALU instructions with no returns -> tags 0,1,2,3 one cycle after each accept. 5th ALU instruction: in_ready = 0. Pulse credit_ret[0] -> accepted next cycle with tag 4.
- 16 LSU/ALU mix with credits returned and no commits -> rob_full = 1, in_ready = 0. commit_valid for 1 cycle -> next instruction accepted with tag 0 (wrap).
- rob_count = 3, SYSTEM instruction presented -> SERIAL_WAIT, serial_busy = 1. Three commits -> RUN, SYSTEM accepted with disp_unit = 3. Then SERIAL_WAIT until its commit.
- head = 2, tail = 9, flush with flush_tag = 4 -> rob_count = 3, next tag 5, in_ready low for 2 cycles, credits at max.
- Accept plus commit plus credit_ret for the same class in one cycle -> rob_count and that credit unchanged.
- reset_n low mid-burst, asynchronous to clk -> disp_valid = 0 and rob_count = 0 immediately. First tag after release is 0.
